axi_mem_responder: RTL and testbench
====================================

Name: axi_mem_responder

Overview:
- AXI4 slave (responder) backed by an internal RAM.
- It is the other end of the DRAM controller's AXI master port. It stands in for the MIG AXI slave in simulation and in BRAM-only builds.
- Write (AW/W/B) and read (AR/R) channels run fully independently.
- Supports FIXED and INCR bursts of up to 256 beats, with per-byte strobes.

Parameters:
- APP_ADDR_WIDTH, 28, byte address width of AW/AR.
- APP_DATA_WIDTH, 128, data beat width in bits (16 bytes).
- APP_MASK_WIDTH, 16, strobe width = APP_DATA_WIDTH/8.
- MEM_WORDS_LOG2, 12, log2 of RAM depth in data words.

Ports:
- ui_clk  in  1  single clock.
- ui_rst  in  1  synchronous, active-high reset.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  4/APP_ADDR_WIDTH/8/3/2  write address.
- s_axi_awlock/awcache/awprot/awqos  in  1/4/3/4  accepted, ignored.
- s_axi_awvalid  in  1.
- s_axi_awready  out  1.
- s_axi_wdata  in  APP_DATA_WIDTH.
- s_axi_wstrb  in  APP_MASK_WIDTH.
- s_axi_wlast  in  1.
- s_axi_wvalid  in  1.
- s_axi_wready  out  1.
- s_axi_bid  out  4.
- s_axi_bresp  out  2.
- s_axi_bvalid  out  1.
- s_axi_bready  in  1.
- s_axi_arid/araddr/arlen/arsize/arburst  in  4/APP_ADDR_WIDTH/8/3/2  read address.
- s_axi_arlock/arcache/arprot/arqos  in  1/4/3/4  ignored.
- s_axi_arvalid  in  1.
- s_axi_arready  out  1.
- s_axi_rid  out  4.
- s_axi_rdata  out  APP_DATA_WIDTH.
- s_axi_rresp  out  2.
- s_axi_rlast  out  1.
- s_axi_rvalid  out  1.
- s_axi_rready  in  1.

Behaviour:
- Reset, while ui_rst=1: every output = 0 (awready, wready, bvalid, arready, rvalid, rlast, bid, rid, bresp, rresp, rdata). Both FSMs go to IDLE. RAM contents are not cleared.
- Reset mid-burst: the burst is abandoned and no B or R beat is issued. Beats already written stay in RAM.
- Word index = addr[4+MEM_WORDS_LOG2-1:4]. addr[3:0] and awsize/arsize are ignored; every beat is a full 16-byte word.
- Next beat address: FIXED (00) keeps the same index. INCR (01) and WRAP (10, treated as INCR) add 1, wrapping modulo 2^MEM_WORDS_LOG2.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On awvalid&awready, latch id/addr/len/burst, clear the beat counter, set awready=0 and wready=1, go to W_DATA.
  - W_DATA: each wvalid&wready beat writes byte i of the addressed word iff wstrb[i]=1, then increments the beat counter.
  - W_DATA exit: on the beat where counter==awlen, set wready=0, bvalid=1, bid=latched id, bresp=00, go to W_RESP. Termination is counter-based; wlast is not used for it.
  - W_RESP: hold bvalid/bid/bresp until bready. On handshake, set bvalid=0 and awready=1 (same edge), go to W_IDLE.
  - Latency: bvalid rises the cycle after the last W handshake. With bready tied 1, awready returns 1 cycle after that.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On arvalid&arready, latch the request, set arready=0, go to R_DATA.
  - R_DATA: RAM read has 1-cycle latency, so the first rvalid rises 2 cycles after the AR handshake.
  - Each beat: rdata, rid and rresp=00 are registered. rlast=1 only on beat arlen. All are held stable while rvalid&!rready.
  - Beat advance: after a handshake, the next beat's rvalid is presented 1 cycle later (no back-to-back requirement). Any pipelined implementation is allowed provided ordering and stability hold.
  - After the final handshake: rvalid=0, rlast=0, arready=1 next cycle, back to R_IDLE.
- Simultaneous AW and AR are both accepted in the same cycle.
- Same-word read and write in the same cycle: the read returns the old data (read-first).
- Only one outstanding transaction per channel. There is no ID reordering.

Optional Feature:
- Macro: AXI_MEM_RESPONDER_DECERR_EN.
- When defined: a transaction whose starting address has any bit in [APP_ADDR_WIDTH-1 : 4+MEM_WORDS_LOG2] set is a decode error.
  - Write: all data beats are accepted and discarded; bresp=11.
  - Read: every beat returns rdata=0 with rresp=11, and rlast is normal.
- When not defined: upper address bits are ignored (memory aliases) and resp is always 00.

Test Plan:
- Write awaddr=0x100, len=0, FIXED, wdata=0x0011..FF, wstrb=0xFFFF, bready=1 -> bvalid=1 for one cycle, bresp=00, bid=awid. Then read 0x100 len=0 -> rdata=0x0011..FF, rlast=1, rresp=00, rvalid exactly 2 cycles after the AR handshake.
- Fill 0x100 with all-ones, then write wdata=0 with wstrb=0x000F -> readback is 0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000.
- INCR write at 0x200, awid=3, len=3, beats A,B,C,D; then INCR read at 0x200, arid=5, len=3 -> 4 beats A,B,C,D, rid=5, rlast only on D.
- Read burst len=3 with rready held low 3 cycles at beat 2 -> rdata/rlast/rvalid stable throughout; all 4 beats delivered in order, none lost or duplicated.
- Write with bready low 5 cycles -> bvalid held high and awready stays 0 until the B handshake, then awready=1. Concurrent read on another address completes meanwhile.
- Assert ui_rst during beat 2 of a len=3 write -> all outputs 0 the next cycle. A following len=0 write/read to 0x300 completes normally. With DECERR_EN, a read at 0x8000000 -> rresp=11, rdata=0.

Source files
------------

// File: rtl/axi_mem_responder_if.sv
// AXI4 memory-port bundle between the DRAM controller (master) and its memory-side slave.
// The slave modport is the responder view; the master modport is the controller view.
interface axi_mem_responder_if #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16
);
  logic [3:0]                awid;
  logic [APP_ADDR_WIDTH-1:0] awaddr;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      awlock;
  logic [3:0]                awcache;
  logic [2:0]                awprot;
  logic [3:0]                awqos;
  logic                      awvalid;
  logic                      awready;
  logic [APP_DATA_WIDTH-1:0] wdata;
  logic [APP_MASK_WIDTH-1:0] wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;
  logic [3:0]                bid;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [3:0]                arid;
  logic [APP_ADDR_WIDTH-1:0] araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      arlock;
  logic [3:0]                arcache;
  logic [2:0]                arprot;
  logic [3:0]                arqos;
  logic                      arvalid;
  logic                      arready;
  logic [3:0]                rid;
  logic [APP_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an internal RAM; independent write and read FSMs, FIXED/INCR bursts.
// Optional AXI_MEM_RESPONDER_DECERR_EN: addresses beyond the RAM return DECERR instead of aliasing.
module axi_mem_responder #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int MEM_WORDS_LOG2 = 12
) (
  input  logic               ui_clk,
  input  logic               ui_rst,
  axi_mem_responder_if.slave s_axi
);

  localparam int IDX_W = MEM_WORDS_LOG2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [1:0]       burst);
    return (burst == 2'b00) ? idx : idx + IDX_W'(1);
  endfunction

  logic [APP_DATA_WIDTH-1:0] mem [2**IDX_W];

  logic aw_dec;
  logic ar_dec;
`ifdef AXI_MEM_RESPONDER_DECERR_EN
  assign aw_dec = |s_axi.awaddr[APP_ADDR_WIDTH-1:4+IDX_W];
  assign ar_dec = |s_axi.araddr[APP_ADDR_WIDTH-1:4+IDX_W];
`else
  assign aw_dec = 1'b0;
  assign ar_dec = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, s_axi.awaddr[3:0], s_axi.awsize, s_axi.awlock, s_axi.awcache,
                       s_axi.awprot, s_axi.awqos, s_axi.wlast, s_axi.araddr[3:0], s_axi.arsize,
                       s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos,
                       s_axi.awaddr[APP_ADDR_WIDTH-1:4+IDX_W], s_axi.araddr[APP_ADDR_WIDTH-1:4+IDX_W]};

  // Write channel state
  w_state_t         w_state;
  logic             awready_q, wready_q, bvalid_q;
  logic [3:0]       bid_q, w_id;
  logic [1:0]       bresp_q, w_burst;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_len, w_cnt;
  logic             w_dec;
  logic             mem_we;

  assign mem_we = (w_state == W_DATA) && s_axi.wvalid && wready_q && !w_dec && !ui_rst;

  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (s_axi.awvalid && awready_q) begin
            w_id      <= s_axi.awid;
            w_idx     <= s_axi.awaddr[4 +: IDX_W];
            w_len     <= s_axi.awlen;
            w_burst   <= s_axi.awburst;
            w_dec     <= aw_dec;
            w_cnt     <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state   <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (s_axi.wvalid && wready_q) begin
            w_cnt <= w_cnt + 8'd1;
            w_idx <= next_idx(w_idx, w_burst);
            // The burst ends on the beat count, not on wlast.
            if (w_cnt == w_len) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= w_id;
              bresp_q  <= w_dec ? 2'b11 : 2'b00;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: vld_p0 = RAM read of the first beat pending, vld_p1 = RAM output valid
  r_state_t                  r_state;
  logic                      arready_q, rvalid_q, rlast_q;
  logic [3:0]                rid_q, r_id;
  logic [1:0]                rresp_q, r_burst;
  logic [APP_DATA_WIDTH-1:0] rdata_q, ram_q_p1;
  logic [IDX_W-1:0]          r_idx, rd_idx;
  logic [7:0]                r_len, r_cnt;
  logic                      r_dec;
  logic                      vld_p0, vld_p1;
  logic                      r_hs, rd_en;

  assign r_hs   = rvalid_q && s_axi.rready;
  assign rd_en  = vld_p0 || (r_hs && !rlast_q);
  assign rd_idx = vld_p0 ? r_idx : next_idx(r_idx, r_burst);

  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      vld_p1 <= rd_en;
      unique case (r_state)
        R_IDLE: begin
          if (s_axi.arvalid && arready_q) begin
            r_id      <= s_axi.arid;
            r_idx     <= s_axi.araddr[4 +: IDX_W];
            r_len     <= s_axi.arlen;
            r_burst   <= s_axi.arburst;
            r_dec     <= ar_dec;
            r_cnt     <= '0;
            arready_q <= 1'b0;
            vld_p0    <= 1'b1;
            r_state   <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (vld_p1) begin
            rvalid_q <= 1'b1;
            rdata_q  <= r_dec ? '0 : ram_q_p1;
            rid_q    <= r_id;
            rresp_q  <= r_dec ? 2'b11 : 2'b00;
            rlast_q  <= (r_cnt == r_len);
          end else if (r_hs) begin
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
              r_idx <= next_idx(r_idx, r_burst);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // RAM: byte-masked write port, registered read-first read port
  always_ff @(posedge ui_clk) begin
    if (mem_we) begin
      for (int b = 0; b < APP_MASK_WIDTH; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
    if (rd_en) ram_q_p1 <= mem[rd_idx];
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed scenarios plus randomized bursts against a byte-level memory model.
`timescale 1ns/1ps
module tb_axi_mem_responder;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;

  logic ui_clk = 1'b0;
  logic ui_rst;
  always #5 ui_clk = ~ui_clk;

  axi_mem_responder_if #(.APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW)) bus ();

  axi_mem_responder #(.APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW),
                      .MEM_WORDS_LOG2(12)) dut (
    .ui_clk(ui_clk),
    .ui_rst(ui_rst),
    .s_axi (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [4096];
  logic [DW-1:0] wd [256];
  logic [MW-1:0] ws [256];

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast,
                        bus.bid, bus.rid, bus.bresp, bus.rresp}, '0);
    chk({tag, "_rdata"}, bus.rdata, '0);
  endtask

  // Addresses at or above 64 KiB fall outside the 4096 x 16-byte RAM.
  function automatic logic is_dec(input logic [AW-1:0] a);
`ifdef AXI_MEM_RESPONDER_DECERR_EN
    return a >= 28'h10000;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int beat_idx(input logic [AW-1:0] a, input int k, input logic [1:0] burst);
    int base;
    base = int'((a / 16) % 4096);
    return (burst == 2'b00) ? base : (base + k) % 4096;
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [AW-1:0] addr, input int len,
                           input logic [1:0] burst, input int b_stall, input int rst_beat);
    int n;
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len); bus.awburst = burst;
    bus.awsize = 3'd4; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 64) begin tick(); n++; end
    chk("aw_ready", bus.awready, 1);
    tick();
    bus.awvalid = 1'b0;
    chk("aw_closed", bus.awready, 0);
    for (int k = 0; k <= len; k++) begin
      bus.wdata = wd[k]; bus.wstrb = ws[k]; bus.wlast = (k == len); bus.wvalid = 1'b1;
      if (k == rst_beat) begin
        ui_rst = 1'b1;
        tick();
        chk_zero("rst_mid_burst");
        ui_rst = 1'b0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
        return;
      end
      n = 0;
      while (!bus.wready && n < 64) begin tick(); n++; end
      chk("w_ready", bus.wready, 1);
      tick();
      if (!is_dec(addr))
        for (int b = 0; b < MW; b++)
          if (ws[k][b]) model[beat_idx(addr, k, burst)][8*b +: 8] = wd[k][8*b +: 8];
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    chk("b_valid", bus.bvalid, 1);
    chk("b_id", bus.bid, id);
    chk("b_resp", bus.bresp, is_dec(addr) ? 3 : 0);
    chk("w_ready_low", bus.wready, 0);
    for (int s = 0; s < b_stall; s++) begin
      tick();
      chk("b_hold", bus.bvalid, 1);
      chk("aw_blocked", bus.awready, 0);
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("b_done", bus.bvalid, 0);
    chk("aw_reopen", bus.awready, 1);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [AW-1:0] addr, input int len,
                          input logic [1:0] burst, input int stall_beat, input int stall_n);
    int n;
    logic [DW-1:0] exp_d;
    logic dec;
    dec = is_dec(addr);
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len); bus.arburst = burst;
    bus.arsize = 3'd4; bus.arvalid = 1'b1; bus.rready = 1'b0;
    n = 0;
    while (!bus.arready && n < 64) begin tick(); n++; end
    chk("ar_ready", bus.arready, 1);
    tick();
    bus.arvalid = 1'b0;
    chk("r_lat0", bus.rvalid, 0);
    tick();
    chk("r_lat1", bus.rvalid, 0);
    tick();
    chk("r_lat2", bus.rvalid, 1);
    for (int k = 0; k <= len; k++) begin
      n = 0;
      while (!bus.rvalid && n < 64) begin tick(); n++; end
      exp_d = dec ? '0 : model[beat_idx(addr, k, burst)];
      chk("r_valid", bus.rvalid, 1);
      chk("r_data", bus.rdata, exp_d);
      chk("r_id", bus.rid, id);
      chk("r_resp", bus.rresp, dec ? 3 : 0);
      chk("r_last", bus.rlast, k == len);
      if (k == stall_beat)
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk("r_hold_valid", bus.rvalid, 1);
          chk("r_hold_data", bus.rdata, exp_d);
          chk("r_hold_last", bus.rlast, k == len);
        end
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
    end
    chk("r_end_valid", bus.rvalid, 0);
    chk("r_end_last", bus.rlast, 0);
    chk("r_end_arready", bus.arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int len, start;
    logic [1:0] burst;
    logic [AW-1:0] addr;

    ui_rst = 1'b1;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    tick(); tick(); tick();
    chk_zero("reset");
    ui_rst = 1'b0;
    tick();
    chk("idle_awready", bus.awready, 1);
    chk("idle_arready", bus.arready, 1);

    // Single-beat write and readback
    wd[0] = 128'h00112233445566778899AABBCCDDEEFF; ws[0] = 16'hFFFF;
    axi_write(4'h6, 28'h100, 0, 2'b00, 0, -1);
    axi_read(4'h2, 28'h100, 0, 2'b00, -1, 0);

    // Byte strobes
    wd[0] = '1; ws[0] = 16'hFFFF;
    axi_write(4'h1, 28'h100, 0, 2'b01, 0, -1);
    wd[0] = '0; ws[0] = 16'h000F;
    axi_write(4'h1, 28'h100, 0, 2'b01, 0, -1);
    axi_read(4'h1, 28'h100, 0, 2'b01, -1, 0);
    chk("strobe_word", bus.rdata, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);

    // INCR burst A..D, then readback with and without a stall on beat 2
    for (int k = 0; k < 4; k++) begin
      wd[k] = {$urandom, $urandom, $urandom, $urandom}; ws[k] = 16'hFFFF;
    end
    axi_write(4'h3, 28'h200, 3, 2'b01, 0, -1);
    axi_read(4'h5, 28'h200, 3, 2'b01, -1, 0);
    axi_read(4'h5, 28'h200, 3, 2'b01, 2, 3);

    // Preload words 0x100..0x1FF (byte addresses 0x1000..0x1FFF) for the random phase
    for (int k = 0; k < 256; k++) begin
      wd[k] = {$urandom, $urandom, $urandom, $urandom}; ws[k] = 16'hFFFF;
    end
    axi_write(4'h0, 28'h1000, 255, 2'b01, 0, -1);

    // Stalled B response with an independent read burst in flight
    wd[0] = {$urandom, $urandom, $urandom, $urandom}; ws[0] = 16'hFFFF;
    wd[1] = {$urandom, $urandom, $urandom, $urandom}; ws[1] = 16'hFFFF;
    fork
      axi_write(4'h9, 28'h500, 1, 2'b01, 5, -1);
      axi_read(4'hA, 28'h1200, 7, 2'b01, -1, 0);
    join

    // Reset during beat 2 of a 4-beat write
    for (int k = 0; k < 4; k++) begin
      wd[k] = {$urandom, $urandom, $urandom, $urandom}; ws[k] = 16'hFFFF;
    end
    axi_write(4'h7, 28'h400, 3, 2'b01, 0, 2);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("no_b_after_rst", bus.bvalid, 0);
      chk("no_r_after_rst", bus.rvalid, 0);
    end
    wd[0] = {$urandom, $urandom, $urandom, $urandom}; ws[0] = 16'hFFFF;
    axi_write(4'h2, 28'h300, 0, 2'b00, 0, -1);
    axi_read(4'h2, 28'h300, 0, 2'b00, -1, 0);
    axi_read(4'h4, 28'h400, 1, 2'b01, -1, 0);

`ifdef AXI_MEM_RESPONDER_DECERR_EN
    wd[0] = '1; ws[0] = 16'hFFFF; wd[1] = '1; ws[1] = 16'hFFFF;
    axi_write(4'hB, 28'h8000000, 1, 2'b01, 0, -1);
    axi_read(4'hC, 28'h8000000, 1, 2'b01, -1, 0);
    axi_read(4'hC, 28'h0, 0, 2'b01, -1, 0);
`endif

    // Randomized bursts inside the preloaded region
    for (int t = 0; t < 24; t++) begin
      len   = $urandom_range(0, 15);
      burst = 2'($urandom_range(0, 2));
      start = $urandom_range(256, 511 - len);
      addr  = AW'(start * 16 + $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) addr[AW-1:16] = 12'($urandom);
      for (int k = 0; k <= len; k++) begin
        wd[k] = {$urandom, $urandom, $urandom, $urandom};
        ws[k] = 16'($urandom);
      end
      axi_write(4'($urandom), addr, len, burst, $urandom_range(0, 3), -1);
      axi_read(4'($urandom), addr, len, burst, $urandom_range(0, len), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
